// File: rtl/rtype_control_unit_pkg.sv
// rtype_pkg
// Shared definitions for the R-format control sequencer. It holds the
// following:
//   - the sequencer state encoding
//   - the instruction field positions
//   - the opcode constants
//   - the ALU operation encodings
// No ports: imported by rtype_decode and rtype_control_unit.
package rtype_pkg;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_T0   = 3'd1,
    S_T1   = 3'd2,
    S_T2   = 3'd3,
    S_T3   = 3'd4,
    S_T4   = 3'd5,
    S_T5   = 3'd6,
    S_T6   = 3'd7
  } state_e;

  // Instruction fields: opcode[31:27], ra[26:23] (dest), rb[22:19], rc[18:15]
  localparam int OPC_LSB = 27;
  localparam int RA_LSB  = 23;
  localparam int RB_LSB  = 19;
  localparam int RC_LSB  = 15;
  localparam int OPC_W   = 5;
  localparam int REG_W   = 4;

  localparam logic [OPC_W-1:0] OP_ADD = 5'b00011;
  localparam logic [OPC_W-1:0] OP_SUB = 5'b00100;
  localparam logic [OPC_W-1:0] OP_AND = 5'b01001;
  localparam logic [OPC_W-1:0] OP_OR  = 5'b01010;
  localparam logic [OPC_W-1:0] OP_MUL = 5'b01111;
  localparam logic [OPC_W-1:0] OP_DIV = 5'b10000;

  localparam logic [3:0] ALU_NOP = 4'b0000;
  localparam logic [3:0] ALU_AND = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0011;
  localparam logic [3:0] ALU_OR  = 4'b0100;
  localparam logic [3:0] ALU_MUL = 4'b0101;
  localparam logic [3:0] ALU_DIV = 4'b0110;

endpackage

// File: rtl/rtype_control_unit_decode.sv
// rtype_decode
// Combinational instruction decoder for the R-format sequencer.
// Ports:
//   ir_i         instruction word
//   alu_op_o     ALU select for the opcode (0 when the opcode is unknown)
//   legal_o      opcode known and ra/rb/rc all below NUM_REGS
//   is_muldiv_o  opcode produces a 64-bit HI/LO result
//   ra/rb/rc_oh_o  one-hot register selects (all-zero when out of range)
module rtype_decode
  import rtype_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IR_W     = 32
) (
  input  logic [IR_W-1:0]     ir_i,
  output logic [3:0]          alu_op_o,
  output logic                legal_o,
  output logic                is_muldiv_o,
  output logic [NUM_REGS-1:0] ra_oh_o,
  output logic [NUM_REGS-1:0] rb_oh_o,
  output logic [NUM_REGS-1:0] rc_oh_o
);

  logic [OPC_W-1:0] opc;
  logic [REG_W-1:0] ra, rb, rc;
  logic             op_ok;
  logic             unused_ir;

  assign opc = ir_i[OPC_LSB +: OPC_W];
  assign ra  = ir_i[RA_LSB +: REG_W];
  assign rb  = ir_i[RB_LSB +: REG_W];
  assign rc  = ir_i[RC_LSB +: REG_W];
  assign unused_ir = ^ir_i[RC_LSB-1:0];

  always_comb begin
    alu_op_o    = ALU_NOP;
    op_ok       = 1'b1;
    is_muldiv_o = 1'b0;
    case (opc)
      OP_ADD:  alu_op_o = ALU_ADD;
      OP_SUB:  alu_op_o = ALU_SUB;
      OP_AND:  alu_op_o = ALU_AND;
      OP_OR:   alu_op_o = ALU_OR;
      OP_MUL:  begin alu_op_o = ALU_MUL; is_muldiv_o = 1'b1; end
      OP_DIV:  begin alu_op_o = ALU_DIV; is_muldiv_o = 1'b1; end
      default: op_ok = 1'b0;
    endcase
  end

  // A register index >= NUM_REGS matches no bit, so an all-zero select
  // doubles as the out-of-range flag.
  always_comb begin
    ra_oh_o = '0;
    rb_oh_o = '0;
    rc_oh_o = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      ra_oh_o[i] = (ra == REG_W'(i));
      rb_oh_o[i] = (rb == REG_W'(i));
      rc_oh_o[i] = (rc == REG_W'(i));
    end
  end

  assign legal_o = op_ok & (|ra_oh_o) & (|rb_oh_o) & (|rc_oh_o);

endmodule

// File: rtl/rtype_control_unit.sv
// rtype_control_unit
// Control sequencer that fetches and executes R-format ALU instructions
// (add/sub/and/or/mul/div) by strobing the datapath.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   run                 keep fetching while high
//   mem_ready           memory read data valid this cycle
//   ir                  IR contents from the datapath
//   pc_out..lo_in       datapath strobes
//   gpr_in / gpr_out    one-hot register load / drive selects
//   alu_op              ALU select, valid in T3..T6
//   busy, done, illegal status; instr_count retired-instruction count
module rtype_control_unit
  import rtype_pkg::*;
#(
  parameter int NUM_REGS = 16,
  parameter int IR_W     = 32,
  parameter int COUNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic                mem_ready,
  input  logic [IR_W-1:0]     ir,
  output logic                pc_out,
  output logic                pc_in,
  output logic                inc_pc,
  output logic                mar_in,
  output logic                read,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                ir_in,
  output logic                y_in,
  output logic                z_in,
  output logic                z_low_out,
  output logic                z_high_out,
  output logic                hi_in,
  output logic                lo_in,
  output logic [NUM_REGS-1:0] gpr_in,
  output logic [NUM_REGS-1:0] gpr_out,
  output logic [3:0]          alu_op,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic [COUNT_W-1:0]  instr_count
);

  state_e               state_q, state_d;
  logic [COUNT_W-1:0]   cnt_q, cnt_d;
  logic [3:0]           dec_alu;
  logic                 dec_legal, dec_muldiv;
  logic [NUM_REGS-1:0]  ra_oh, rb_oh, rc_oh;

  rtype_decode #(.NUM_REGS(NUM_REGS), .IR_W(IR_W)) u_decode (
    .ir_i        (ir),
    .alu_op_o    (dec_alu),
    .legal_o     (dec_legal),
    .is_muldiv_o (dec_muldiv),
    .ra_oh_o     (ra_oh),
    .rb_oh_o     (rb_oh),
    .rc_oh_o     (rc_oh)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (run) state_d = S_T0;
      S_T0:   state_d = S_T1;
      S_T1:   if (mem_ready) state_d = S_T2;
      S_T2:   state_d = S_T3;
      S_T3:   state_d = dec_legal ? S_T4 : S_IDLE;
      S_T4:   state_d = S_T5;
      // run is only consulted at the retiring cycle, so dropping it
      // mid-instruction never truncates the instruction.
      S_T5:   state_d = dec_muldiv ? S_T6 : (run ? S_T0 : S_IDLE);
      S_T6:   state_d = run ? S_T0 : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  assign cnt_d = cnt_q + COUNT_W'(done);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign instr_count = cnt_q;
  assign busy        = (state_q != S_IDLE);

  // Moore strobe decode. ir is only trusted from T3 on, after the IR load.
  always_comb begin
    pc_out = 1'b0; pc_in = 1'b0; inc_pc = 1'b0; mar_in = 1'b0;
    read = 1'b0; mdr_in = 1'b0; mdr_out = 1'b0; ir_in = 1'b0;
    y_in = 1'b0; z_in = 1'b0; z_low_out = 1'b0; z_high_out = 1'b0;
    hi_in = 1'b0; lo_in = 1'b0;
    gpr_in = '0; gpr_out = '0;
    alu_op = ALU_NOP;
    done = 1'b0; illegal = 1'b0;
    case (state_q)
      S_T0: begin pc_out = 1'b1; mar_in = 1'b1; inc_pc = 1'b1; end
      S_T1: begin read = 1'b1; mdr_in = 1'b1; end
      S_T2: begin mdr_out = 1'b1; ir_in = 1'b1; end
      S_T3: begin
        // An undecodable instruction drives nothing, not even alu_op.
        if (dec_legal) begin
          gpr_out = rb_oh; y_in = 1'b1; alu_op = dec_alu;
        end else begin
          illegal = 1'b1;
        end
      end
      S_T4: begin gpr_out = rc_oh; z_in = 1'b1; alu_op = dec_alu; end
      S_T5: begin
        z_low_out = 1'b1;
        alu_op    = dec_alu;
        if (dec_muldiv) begin
          lo_in = 1'b1;
        end else begin
          gpr_in = ra_oh; done = 1'b1;
        end
      end
      S_T6: begin z_high_out = 1'b1; hi_in = 1'b1; done = 1'b1; alu_op = dec_alu; end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rtype_control_unit.sv
module tb_rtype_control_unit;

  localparam int NR = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT with 16 registers ----------------
  logic        reset_n, run, mem_ready;
  logic [31:0] ir;
  logic pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in;
  logic y_in, z_in, z_low_out, z_high_out, hi_in, lo_in, busy, done, illegal;
  logic [15:0] gpr_in, gpr_out, instr_count;
  logic [3:0]  alu_op;

  rtype_control_unit #(.NUM_REGS(16), .IR_W(32), .COUNT_W(16)) dut (
    .clk(clk), .reset_n(reset_n), .run(run), .mem_ready(mem_ready), .ir(ir),
    .pc_out(pc_out), .pc_in(pc_in), .inc_pc(inc_pc), .mar_in(mar_in),
    .read(read), .mdr_in(mdr_in), .mdr_out(mdr_out), .ir_in(ir_in),
    .y_in(y_in), .z_in(z_in), .z_low_out(z_low_out), .z_high_out(z_high_out),
    .hi_in(hi_in), .lo_in(lo_in), .gpr_in(gpr_in), .gpr_out(gpr_out),
    .alu_op(alu_op), .busy(busy), .done(done), .illegal(illegal),
    .instr_count(instr_count)
  );

  // ---------------- DUT with 8 registers ----------------
  logic        run8;
  logic [31:0] ir8;
  logic e_pc_out, e_pc_in, e_inc_pc, e_mar_in, e_read, e_mdr_in, e_mdr_out, e_ir_in;
  logic e_y_in, e_z_in, e_z_low_out, e_z_high_out, e_hi_in, e_lo_in;
  logic e_busy, e_done, e_illegal;
  logic [7:0]  e_gpr_in, e_gpr_out;
  logic [3:0]  e_alu_op;
  logic [15:0] e_count;

  rtype_control_unit #(.NUM_REGS(8), .IR_W(32), .COUNT_W(16)) dut8 (
    .clk(clk), .reset_n(reset_n), .run(run8), .mem_ready(mem_ready), .ir(ir8),
    .pc_out(e_pc_out), .pc_in(e_pc_in), .inc_pc(e_inc_pc), .mar_in(e_mar_in),
    .read(e_read), .mdr_in(e_mdr_in), .mdr_out(e_mdr_out), .ir_in(e_ir_in),
    .y_in(e_y_in), .z_in(e_z_in), .z_low_out(e_z_low_out), .z_high_out(e_z_high_out),
    .hi_in(e_hi_in), .lo_in(e_lo_in), .gpr_in(e_gpr_in), .gpr_out(e_gpr_out),
    .alu_op(e_alu_op), .busy(e_busy), .done(e_done), .illegal(e_illegal),
    .instr_count(e_count)
  );

  // ---------------- bookkeeping ----------------
  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0;

  typedef struct packed {
    logic pc_out, pc_in, inc_pc, mar_in, read, mdr_in, mdr_out, ir_in;
    logic y_in, z_in, z_low_out, z_high_out, hi_in, lo_in;
    logic busy, done, illegal;
    logic [3:0]  alu_op;
    logic [15:0] gpr_in, gpr_out, cnt;
  } out_t;

  typedef struct packed {
    logic        run;
    logic        mem_ready;
    logic [31:0] ir;
    out_t        exp;
  } step_t;

  step_t tq[$];
  int    mcnt;
  logic [31:0] last_ir;

  function automatic out_t sample();
    out_t o;
    o.pc_out = pc_out; o.pc_in = pc_in; o.inc_pc = inc_pc; o.mar_in = mar_in;
    o.read = read; o.mdr_in = mdr_in; o.mdr_out = mdr_out; o.ir_in = ir_in;
    o.y_in = y_in; o.z_in = z_in; o.z_low_out = z_low_out; o.z_high_out = z_high_out;
    o.hi_in = hi_in; o.lo_in = lo_in; o.busy = busy; o.done = done; o.illegal = illegal;
    o.alu_op = alu_op; o.gpr_in = gpr_in; o.gpr_out = gpr_out; o.cnt = instr_count;
    return o;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string nm, input out_t act, input out_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h @%0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Instruction semantics straight from the opcode table.
  function automatic void ref_decode(input logic [31:0] w, input int nregs,
                                     output logic ok, output logic md,
                                     output logic [3:0] aop);
    int ra, rb, rc;
    ra = int'(w[26:23]); rb = int'(w[22:19]); rc = int'(w[18:15]);
    ok = 1'b1; md = 1'b0; aop = 4'd0;
    case (w[31:27])
      5'b00011: aop = 4'b0010;
      5'b00100: aop = 4'b0011;
      5'b01001: aop = 4'b0001;
      5'b01010: aop = 4'b0100;
      5'b01111: begin aop = 4'b0101; md = 1'b1; end
      5'b10000: begin aop = 4'b0110; md = 1'b1; end
      default:  ok = 1'b0;
    endcase
    if (ra >= nregs || rb >= nregs || rc >= nregs) ok = 1'b0;
    if (!ok) aop = 4'd0;
  endfunction

  task automatic emit(inout step_t s, input int run_until, inout int off);
    s.run      = (off < run_until);
    s.exp.busy = 1'b1;
    s.exp.cnt  = 16'(mcnt);
    tq.push_back(s);
    if (s.exp.done) mcnt++;
    off++;
  endtask

  task automatic add_idle(input logic r);
    step_t s;
    s = '0;
    s.run = r; s.mem_ready = 1'b1; s.ir = last_ir; s.exp.cnt = 16'(mcnt);
    tq.push_back(s);
  endtask

  // Expected cycle-by-cycle behaviour of one instruction: fetch (one cycle),
  // wt+1 read cycles, IR load, then operand/result cycles. b2b reports
  // whether run is still high in the final cycle.
  task automatic add_instr(input logic [31:0] w, input int wt, input int run_until_in,
                           output logic b2b);
    step_t base, s;
    logic ok, md;
    logic [3:0] aop;
    int off, run_until;
    ref_decode(w, NR, ok, md, aop);
    run_until = ok ? run_until_in : 0;
    last_ir = w;
    base = '0; base.ir = w; base.mem_ready = 1'b1;
    off = 0;
    s = base; s.exp.pc_out = 1; s.exp.mar_in = 1; s.exp.inc_pc = 1; emit(s, run_until, off);
    for (int j = 0; j <= wt; j++) begin
      s = base; s.exp.read = 1; s.exp.mdr_in = 1; s.mem_ready = (j == wt);
      emit(s, run_until, off);
    end
    s = base; s.exp.mdr_out = 1; s.exp.ir_in = 1; emit(s, run_until, off);
    if (!ok) begin
      s = base; s.exp.illegal = 1; emit(s, run_until, off);
      b2b = 1'b0;
      return;
    end
    s = base; s.exp.gpr_out = 16'(1) << w[22:19]; s.exp.y_in = 1; s.exp.alu_op = aop;
    emit(s, run_until, off);
    s = base; s.exp.gpr_out = 16'(1) << w[18:15]; s.exp.z_in = 1; s.exp.alu_op = aop;
    emit(s, run_until, off);
    s = base; s.exp.z_low_out = 1; s.exp.alu_op = aop;
    if (md) s.exp.lo_in = 1;
    else begin s.exp.gpr_in = 16'(1) << w[26:23]; s.exp.done = 1; end
    emit(s, run_until, off);
    if (md) begin
      s = base; s.exp.z_high_out = 1; s.exp.hi_in = 1; s.exp.done = 1; s.exp.alu_op = aop;
      emit(s, run_until, off);
    end
    b2b = (off - 1 < run_until);
  endtask

  task automatic apply_trace(input string nm);
    step_t s;
    while (tq.size() > 0) begin
      s = tq.pop_front();
      @(posedge clk); #1;
      run = s.run; mem_ready = s.mem_ready; ir = s.ir;
      @(negedge clk);
      chk_out(nm, sample(), s.exp);
    end
    exp_cnt = mcnt;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    string       nm;
    logic [31:0] w;
    int          wt;
    int          lat;
    logic [3:0]  aop;
    logic [15:0] gin;
    logic        ill;
  } vec_t;

  task automatic run_one(input vec_t v);
    int c, reads;
    logic ended, got_done, got_ill;
    logic [3:0]  got_alu;
    logic [15:0] gacc;
    @(posedge clk); #1;
    run = 1'b1; ir = v.w; mem_ready = 1'b1;
    c = 0; reads = 0; ended = 0; gacc = '0; got_done = 0; got_ill = 0; got_alu = '0;
    while (!ended && c < 40) begin
      @(posedge clk); #1;
      run = 1'b0;
      mem_ready = !(c >= 1 && c <= v.wt);
      @(negedge clk);
      gacc |= gpr_in;
      if (read && mdr_in) reads++;
      if (done || illegal) begin
        ended = 1; got_done = done; got_ill = illegal; got_alu = alu_op;
      end
      c++;
    end
    chk({v.nm, " ended"}, 32'(ended), 32'd1);
    chk({v.nm, " latency"}, c, v.lat);
    chk({v.nm, " read cycles"}, reads, v.wt + 1);
    chk({v.nm, " alu_op"}, 32'(got_alu), 32'(v.aop));
    chk({v.nm, " gpr_in"}, 32'(gacc), 32'(v.gin));
    chk({v.nm, " illegal"}, 32'(got_ill), 32'(v.ill));
    chk({v.nm, " done"}, 32'(got_done), 32'(!v.ill));
    if (!v.ill) exp_cnt++;
    @(posedge clk); #1;
    @(negedge clk);
    chk({v.nm, " idle after"}, 32'(busy), 32'd0);
    chk({v.nm, " count"}, 32'(instr_count), 32'(exp_cnt));
  endtask

  initial begin
    vec_t tbl[8];
    logic b;
    logic [31:0] w;
    int wt, ru;
    out_t zero;
    logic seen_ill, seen_done;
    int c;

    tbl[0] = '{"and",      32'h4A920000, 0, 6, 4'b0001, 16'h0020, 1'b0};
    tbl[1] = '{"and_wait3",32'h4A920000, 3, 9, 4'b0001, 16'h0020, 1'b0};
    tbl[2] = '{"add",      32'h1A920000, 0, 6, 4'b0010, 16'h0020, 1'b0};
    tbl[3] = '{"sub_wait1",32'h22920000, 1, 7, 4'b0011, 16'h0020, 1'b0};
    tbl[4] = '{"or",       32'h52920000, 0, 6, 4'b0100, 16'h0020, 1'b0};
    tbl[5] = '{"mul",      32'h79198000, 0, 7, 4'b0101, 16'h0000, 1'b0};
    tbl[6] = '{"div_wait2",32'h80918000, 2, 9, 4'b0110, 16'h0000, 1'b0};
    tbl[7] = '{"illegal",  32'hFA920000, 0, 4, 4'b0000, 16'h0000, 1'b1};

    reset_n = 1'b0; run = 1'b0; mem_ready = 1'b1; ir = '0; run8 = 1'b0; ir8 = '0;
    zero = '0;
    #1;
    chk_out("reset outputs", sample(), zero);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    chk_out("idle after reset", sample(), zero);

    for (int i = 0; i < 8; i++) run_one(tbl[i]);

    // Three back-to-back instructions, run dropped during T4 of the third.
    mcnt = exp_cnt; last_ir = ir;
    add_idle(1'b1);
    add_instr(32'h4A920000, 0, 1000, b);
    add_instr(32'h79198000, 1, 1000, b);
    add_instr(32'h1A920000, 0, 4, b);
    add_idle(1'b0);
    add_idle(1'b0);
    apply_trace("b2b");
    chk("b2b count", 32'(instr_count), 32'(exp_cnt));

    // Random instruction stream.
    b = 1'b0;
    for (int n = 0; n < 40; n++) begin
      w = $urandom;
      case ($urandom_range(0, 6))
        0: w[31:27] = 5'b00011;
        1: w[31:27] = 5'b00100;
        2: w[31:27] = 5'b01001;
        3: w[31:27] = 5'b01010;
        4: w[31:27] = 5'b01111;
        5: w[31:27] = 5'b10000;
        default: ;
      endcase
      wt = $urandom_range(0, 3);
      ru = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, 8)) : 1000;
      if (n == 39) ru = 0;
      if (!b) add_idle(1'b1);
      add_instr(w, wt, ru, b);
    end
    add_idle(1'b0);
    apply_trace("random");

    // NUM_REGS=8: rc=R9 is illegal, a legal AND still retires.
    @(posedge clk); #1; run8 = 1'b1; ir8 = 32'h1A948000;
    seen_ill = 0; c = 0;
    while (!seen_ill && c < 20) begin
      @(posedge clk); #1; run8 = 1'b0;
      @(negedge clk);
      if (e_illegal) seen_ill = 1;
      c++;
    end
    chk("n8 rc9 illegal latency", c, 4);
    @(posedge clk); @(negedge clk);
    chk("n8 idle after illegal", 32'(e_busy), 32'd0);
    chk("n8 count after illegal", 32'(e_count), 32'd0);
    @(posedge clk); #1; run8 = 1'b1; ir8 = 32'h4A920000;
    seen_done = 0; c = 0;
    while (!seen_done && c < 20) begin
      @(posedge clk); #1; run8 = 1'b0;
      @(negedge clk);
      if (e_done) begin seen_done = 1; chk("n8 gpr_in", 32'(e_gpr_in), 32'h20); end
      c++;
    end
    chk("n8 and latency", c, 6);
    @(posedge clk); @(negedge clk);
    chk("n8 count", 32'(e_count), 32'd1);

    // Reset during T4 aborts at once; fetch restarts cleanly afterwards.
    @(posedge clk); #1; run = 1'b1; ir = 32'h4A920000; mem_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin @(posedge clk); #1; run = 1'b0; end
    @(negedge clk);
    chk("pre-reset z_in (T4)", 32'(z_in), 32'd1);
    reset_n = 1'b0;
    #1;
    chk_out("async reset outputs", sample(), zero);
    chk("async reset dut8 busy", 32'(e_busy), 32'd0);
    @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1; run = 1'b1;
    @(posedge clk); #1; run = 1'b0;
    @(negedge clk);
    begin
      out_t t0;
      t0 = '0; t0.pc_out = 1; t0.mar_in = 1; t0.inc_pc = 1; t0.busy = 1;
      chk_out("restart T0", sample(), t0);
    end
    seen_done = 0; c = 0;
    while (!seen_done && c < 20) begin
      @(posedge clk); @(negedge clk);
      if (done) seen_done = 1;
      c++;
    end
    chk("restart done reached", 32'(seen_done), 32'd1);
    @(posedge clk); @(negedge clk);
    chk("restart count", 32'(instr_count), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
